// File: rtl/amp_fault_pkg.sv
// Shared state encoding, default timing and counter-width helper for the
// amplifier power-up / fault supervisor.
package amp_fault_pkg;

   typedef enum logic [1:0] {
      ST_STARTUP = 2'b00,
      ST_RUN     = 2'b01,
      ST_FAULT   = 2'b10,
      ST_LOCKOUT = 2'b11
   } amp_state_e;

   localparam int unsigned DEF_NUM_AMP      = 2;
   localparam int unsigned DEF_STARTUP_CYC  = 250000;
   localparam int unsigned DEF_DEBOUNCE_CYC = 16;
   localparam int unsigned DEF_RETRY_CYC    = 2500000;
   localparam int unsigned DEF_MAX_RETRY    = 3;

   // Bits needed to count 0..n-1, never less than one bit.
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/amp_chnl_ctrl.sv
// One amplifier channel: fault synchroniser, debounce, shared timer,
// retry counter and STARTUP/RUN/FAULT/LOCKOUT sequencing.
module amp_chnl_ctrl
   import amp_fault_pkg::*;
#(
   parameter int unsigned STARTUP_CYC  = DEF_STARTUP_CYC,
   parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
   parameter int unsigned RETRY_CYC    = DEF_RETRY_CYC,
   parameter int unsigned MAX_RETRY    = DEF_MAX_RETRY
) (
   input  logic clk,
   input  logic rst_n,
   input  logic flt_n,
   input  logic clr_fault,
   output logic sht_dwn,
   output logic fault_sticky,
   output logic locked_out
);

   localparam int unsigned TMR_MAX = (STARTUP_CYC > RETRY_CYC) ? STARTUP_CYC : RETRY_CYC;
   localparam int unsigned TMR_W   = cnt_w(TMR_MAX);
   localparam int unsigned DEB_W   = cnt_w(DEBOUNCE_CYC);
   localparam int unsigned RTY_W   = cnt_w(MAX_RETRY + 1);

   localparam logic [TMR_W-1:0] START_LAST = TMR_W'(STARTUP_CYC - 1);
   localparam logic [TMR_W-1:0] RETRY_LAST = TMR_W'(RETRY_CYC - 1);
   localparam logic [DEB_W-1:0] DEB_LAST   = DEB_W'(DEBOUNCE_CYC - 1);
   localparam logic [RTY_W-1:0] RTY_MAX    = RTY_W'(MAX_RETRY);

   logic [1:0]       sync_q;
   logic             flt_s;
   amp_state_e       state, next_state;
   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic [DEB_W-1:0] deb_q, deb_d;
   logic [RTY_W-1:0] rty_q, rty_d;
   logic             sht_dwn_d, sticky_d, locked_d;

   // Two-flop synchroniser; idles high so reset never looks like a fault.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= 2'b11;
      else        sync_q <= {sync_q[0], flt_n};
   end

   assign flt_s = sync_q[1];

   // State, counters and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_STARTUP;
         tmr_q        <= '0;
         deb_q        <= '0;
         rty_q        <= '0;
         sht_dwn      <= 1'b1;
         fault_sticky <= 1'b0;
         locked_out   <= 1'b0;
      end else begin
         state        <= next_state;
         tmr_q        <= tmr_d;
         deb_q        <= deb_d;
         rty_q        <= rty_d;
         sht_dwn      <= sht_dwn_d;
         fault_sticky <= sticky_d;
         locked_out   <= locked_d;
      end
   end

   // Next state and counter updates.
   always_comb begin
      next_state = state;
      tmr_d      = tmr_q + TMR_W'(1);
      deb_d      = '0;
      rty_d      = rty_q;
      case (state)
         ST_STARTUP: begin
            if (tmr_q == START_LAST) next_state = ST_RUN;
         end
         ST_RUN: begin
            if (!flt_s) begin
               if (deb_q == DEB_LAST) next_state = ST_FAULT;
               else                   deb_d      = deb_q + DEB_W'(1);
            end
            // Clean-run timer saturates and forgives earlier retries.
            if (tmr_q == RETRY_LAST) begin
               tmr_d = tmr_q;
               if (next_state == ST_RUN) rty_d = '0;
            end
         end
         ST_FAULT: begin
            if (rty_q == RTY_MAX) begin
               next_state = ST_LOCKOUT;
            end else if (tmr_q == RETRY_LAST) begin
               next_state = ST_STARTUP;
               rty_d      = rty_q + RTY_W'(1);
            end
         end
         ST_LOCKOUT: begin
            tmr_d = '0;
            if (clr_fault) begin
               next_state = ST_STARTUP;
               rty_d      = '0;
            end
         end
         default: next_state = ST_STARTUP;
      endcase
      if (next_state != state) begin
         tmr_d = '0;
         deb_d = '0;
      end
   end

   // Outputs decoded from the next state; a FAULT entry beats a same-cycle clear.
   always_comb begin
      sht_dwn_d = (next_state != ST_RUN);
      locked_d  = (next_state == ST_LOCKOUT);
      sticky_d  = fault_sticky;
      if (clr_fault) sticky_d = 1'b0;
      if ((next_state == ST_FAULT) && (state != ST_FAULT)) sticky_d = 1'b1;
   end

endmodule

// File: rtl/amp_fault_mgr.sv
// Multi-amplifier power-up / fault supervisor: one channel controller per
// amp plus a registered mute that is high while any amp is shut down.
module amp_fault_mgr
   import amp_fault_pkg::*;
#(
   parameter int unsigned NUM_AMP      = DEF_NUM_AMP,
   parameter int unsigned STARTUP_CYC  = DEF_STARTUP_CYC,
   parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
   parameter int unsigned RETRY_CYC    = DEF_RETRY_CYC,
   parameter int unsigned MAX_RETRY    = DEF_MAX_RETRY
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_AMP-1:0] Flt_n,
   input  logic               clr_fault,
   output logic [NUM_AMP-1:0] sht_dwn,
   output logic [NUM_AMP-1:0] fault_sticky,
   output logic [NUM_AMP-1:0] locked_out,
   output logic               mute
);

   for (genvar i = 0; i < int'(NUM_AMP); i++) begin : g_chnl
      amp_chnl_ctrl #(
         .STARTUP_CYC  (STARTUP_CYC),
         .DEBOUNCE_CYC (DEBOUNCE_CYC),
         .RETRY_CYC    (RETRY_CYC),
         .MAX_RETRY    (MAX_RETRY)
      ) u_chnl (
         .clk          (clk),
         .rst_n        (rst_n),
         .flt_n        (Flt_n[i]),
         .clr_fault    (clr_fault),
         .sht_dwn      (sht_dwn[i]),
         .fault_sticky (fault_sticky[i]),
         .locked_out   (locked_out[i])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) mute <= 1'b1;
      else        mute <= |sht_dwn;
   end

endmodule
